// File: rtl/phase_sequencer.sv
// Safety phase sequencer: takes a requested lane pattern over valid/ready and walks the
// physical lights through GREEN -> YELLOW -> ALL_RED -> new GREEN with a minimum green time.
module phase_sequencer #(
  parameter int unsigned MIN_GREEN_CYCLES = 8,
  parameter int unsigned YELLOW_CYCLES    = 3,
  parameter int unsigned ALLRED_CYCLES    = 2,
  parameter int unsigned CNT_W            = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] lane_req,
  input  logic       req_valid,
  output logic       req_ready,
  output logic [7:0] lights,
  output logic       phase_done,
  output logic       err
);

  localparam int unsigned LW = 8;
  localparam logic [LW-1:0] PAT_NS = 8'b0011_0011;
  localparam logic [LW-1:0] PAT_EW = 8'b1100_1100;
  localparam logic [CNT_W-1:0] CNT_MIN_GREEN = CNT_W'(MIN_GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_YELLOW    = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ALLRED    = CNT_W'(ALLRED_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_INIT,
    ST_GREEN,
    ST_YELLOW,
    ST_ALL_RED
  } state_e;

  state_e           state_q, state_d;
  logic [LW-1:0]    lights_q, lights_d;
  logic [LW-1:0]    cur_green_q, cur_green_d;
  logic [LW-1:0]    nxt_green_q, nxt_green_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_done_q, phase_done_d;
  logic             err_q, err_d;

  logic accept;
  logic legal;

  // Every green pair (11) becomes yellow (01); red pairs stay red.
  function automatic logic [LW-1:0] to_yellow(input logic [LW-1:0] pat);
    logic [LW-1:0] y;
    y = '0;
    for (int i = 0; i < LW / 2; i++) begin
      y[2*i] = pat[2*i+1] & pat[2*i];
    end
    return y;
  endfunction

  // Ready depends only on registered state so there is no valid->ready path.
  assign req_ready = (state_q == ST_INIT) || ((state_q == ST_GREEN) && (cnt_q == '0));
  assign accept    = req_valid && req_ready;
  assign legal     = (lane_req == PAT_NS) || (lane_req == PAT_EW);

  always_comb begin
    state_d      = state_q;
    lights_d     = lights_q;
    cur_green_d  = cur_green_q;
    nxt_green_d  = nxt_green_q;
    cnt_d        = cnt_q;
    phase_done_d = 1'b0;
    err_d        = 1'b0;

    // An illegal accepted pattern is consumed and flagged, nothing else moves.
    if (accept && !legal) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_INIT: begin
        lights_d = '0;
        if (accept && legal) begin
          cur_green_d = lane_req;
          nxt_green_d = lane_req;
          state_d     = ST_ALL_RED;
          cnt_d       = CNT_ALLRED;
        end
      end
      ST_GREEN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (accept && legal && (lane_req != cur_green_q)) begin
          nxt_green_d = lane_req;
          state_d     = ST_YELLOW;
          cnt_d       = CNT_YELLOW;
          lights_d    = to_yellow(cur_green_q);
        end
      end
      ST_YELLOW: begin
        if (cnt_q == '0) begin
          state_d  = ST_ALL_RED;
          lights_d = '0;
          cnt_d    = CNT_ALLRED;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_ALL_RED: begin
        if (cnt_q == '0) begin
          state_d      = ST_GREEN;
          lights_d     = nxt_green_q;
          cur_green_d  = nxt_green_q;
          cnt_d        = CNT_MIN_GREEN;
          phase_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d  = ST_INIT;
        lights_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      lights_q     <= '0;
      cur_green_q  <= '0;
      nxt_green_q  <= '0;
      cnt_q        <= '0;
      phase_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      lights_q     <= lights_d;
      cur_green_q  <= cur_green_d;
      nxt_green_q  <= nxt_green_d;
      cnt_q        <= cnt_d;
      phase_done_q <= phase_done_d;
      err_q        <= err_d;
    end
  end

  assign lights     = lights_q;
  assign phase_done = phase_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Randomized bench for phase_sequencer against a timestamp-based model of the phase rules,
// with a per-cycle safety invariant monitor.
module tb_phase_sequencer;

  localparam int MIN_G = 8;
  localparam int YEL   = 3;
  localparam int AR    = 2;

  localparam logic [7:0] NS = 8'b0011_0011;
  localparam logic [7:0] EW = 8'b1100_1100;

  localparam int M_IDLE    = 0;
  localparam int M_EW      = 1;
  localparam int M_NS      = 2;
  localparam int M_ILLEGAL = 3;
  localparam int M_TOGGLE  = 4;
  localparam int M_RANDOM  = 5;

  logic       clk;
  logic       rst;
  logic [7:0] lane_req;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] lights;
  logic       phase_done;
  logic       err;

  phase_sequencer #(
    .MIN_GREEN_CYCLES(MIN_G),
    .YELLOW_CYCLES   (YEL),
    .ALLRED_CYCLES   (AR),
    .CNT_W           (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lane_req  (lane_req),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .lights    (lights),
    .phase_done(phase_done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Model: phase boundaries as absolute cycle numbers (cycle n = outputs after edge n).
  bit         m_init;
  logic [7:0] m_prev;
  logic [7:0] m_nxt;
  int         t_y, t_r, t_g, t_ready, err_cyc;
  logic [7:0] last_lights;
  bit         have_last;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] yellow_of(input logic [7:0] p);
    logic [7:0] y;
    y = '0;
    for (int i = 0; i < 4; i++) begin
      if (((p >> (2 * i)) & 8'h3) == 8'h3) y = y | (8'h1 << (2 * i));
    end
    return y;
  endfunction

  function automatic bit m_ready(input int n);
    return m_init || (n >= t_ready);
  endfunction

  function automatic logic [7:0] m_lights(input int n);
    if (m_init)   return 8'h00;
    if (n >= t_g) return m_nxt;
    if (n >= t_r) return 8'h00;
    if (n >= t_y) return yellow_of(m_prev);
    return m_prev;
  endfunction

  task automatic model_reset();
    m_init    = 1'b1;
    m_prev    = 8'h00;
    m_nxt     = 8'h00;
    t_y       = -1;
    t_r       = -1;
    t_g       = -1;
    t_ready   = 0;
    err_cyc   = -1;
    have_last = 1'b0;
    cyc       = 0;
  endtask

  // Apply an accepted request to the model at edge e.
  task automatic model_accept(input int e, input logic [7:0] req);
    if (req != NS && req != EW) begin
      err_cyc = e;
    end else if (m_init) begin
      m_init  = 1'b0;
      m_prev  = 8'h00;
      m_nxt   = req;
      t_y     = e;
      t_r     = e;
      t_g     = e + AR;
      t_ready = t_g + MIN_G - 1;
    end else if (req != m_nxt) begin
      m_prev  = m_nxt;
      m_nxt   = req;
      t_y     = e;
      t_r     = e + YEL;
      t_g     = t_r + AR;
      t_ready = t_g + MIN_G - 1;
    end
  endtask

  task automatic check_safety();
    logic [1:0] a, b;
    bit ns_g, ew_g;
    ns_g = (lights[5:4] == 2'b11) || (lights[1:0] == 2'b11);
    ew_g = (lights[7:6] == 2'b11) || (lights[3:2] == 2'b11);
    check("conflict_green", 32'(ns_g && ew_g), 32'd0);
    for (int i = 0; i < 4; i++) begin
      b = 2'((lights >> (2 * i)) & 8'h3);
      check("reserved_code", 32'(b == 2'b10), 32'd0);
      if (have_last) begin
        a = 2'((last_lights >> (2 * i)) & 8'h3);
        check("green_to_red", 32'(a == 2'b11 && b == 2'b00), 32'd0);
        check("yellow_to_green", 32'(a == 2'b01 && b == 2'b11), 32'd0);
      end
    end
    last_lights = lights;
    have_last   = 1'b1;
  endtask

  task automatic check_cycle();
    check("lights", 32'(lights), 32'(m_lights(cyc)));
    check("req_ready", 32'(req_ready), 32'(m_ready(cyc)));
    check("phase_done", 32'(phase_done), 32'(cyc == t_g));
    check("err", 32'(err), 32'(cyc == err_cyc));
    check_safety();
  endtask

  // Asserts reset away from any clock edge and checks the immediate effect.
  task automatic do_reset();
    req_valid = 1'b0;
    lane_req  = 8'h00;
    #2 rst = 1'b1;
    #1;
    check("rst_lights", 32'(lights), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_phase_done", 32'(phase_done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_cycle();
  endtask

  task automatic run(input int n, input int mode);
    logic [7:0] pat;
    bit v;
    int r;
    for (int k = 0; k < n; k++) begin
      v   = 1'b1;
      pat = 8'h00;
      case (mode)
        M_IDLE:    v = 1'b0;
        M_EW:      pat = EW;
        M_NS:      pat = NS;
        M_ILLEGAL: pat = 8'hFF;
        M_TOGGLE:  pat = cyc[0] ? NS : EW;
        default: begin
          v = ($urandom_range(0, 3) != 0);
          r = $urandom_range(0, 7);
          if (r == 0)     pat = 8'($urandom);
          else if (r < 4) pat = NS;
          else            pat = EW;
        end
      endcase
      req_valid = v;
      lane_req  = v ? pat : 8'($urandom);
      if (v && m_ready(cyc)) model_accept(cyc + 1, pat);
      @(posedge clk);
      cyc++;
      @(negedge clk);
      check_cycle();
    end
  endtask

  initial begin
    rst       = 1'b0;
    req_valid = 1'b0;
    lane_req  = 8'h00;
    model_reset();
    @(negedge clk);
    do_reset();
    run(3, M_IDLE);
    run(1, M_EW);
    run(12, M_IDLE);
    run(1, M_ILLEGAL);
    run(3, M_IDLE);
    run(1, M_NS);
    run(16, M_IDLE);
    run(20, M_NS);
    run(200, M_TOGGLE);
    do_reset();
    run(1, M_ILLEGAL);
    run(2, M_IDLE);
    run(500, M_RANDOM);
    run(5, M_TOGGLE);
    do_reset();
    run(400, M_RANDOM);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
